// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: runs the core for a programmed number of cycles, then
// scans the architectural register file through a registered read port and
// compares every register against a preloaded expected value under a
// per-register bit mask. Reports a mismatch count and the first failure.
module reg_file_scoreboard #(
  parameter int NUM_REGS = 38,
  parameter int DATA_W   = 34,
  parameter int IDX_W    = 6,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic              exp_wr_en,
  input  logic [IDX_W-1:0]  exp_wr_idx,
  input  logic [DATA_W-1:0] exp_wr_data,
  input  logic [DATA_W-1:0] exp_wr_mask,
  output logic              core_run,
  output logic [IDX_W-1:0]  rf_rd_idx,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDX_W:0]    err_count,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_act,
  output logic [DATA_W-1:0] first_err_exp
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  run_len_q, run_len_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              issued_all_q, issued_all_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic [IDX_W-1:0]  cmp_idx_q, cmp_idx_d;
  logic [IDX_W:0]    err_count_q, err_count_d;
  logic [IDX_W-1:0]  first_idx_q, first_idx_d;
  logic [DATA_W-1:0] first_act_q, first_act_d;
  logic [DATA_W-1:0] first_exp_q, first_exp_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              core_run_q, core_run_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] exp_data_q [NUM_REGS];
  logic [DATA_W-1:0] exp_mask_q [NUM_REGS];

  logic              idle_like_s;
  logic              wr_ok_s;
  logic              mismatch_s;

  assign idle_like_s = (state_q == S_IDLE) || (state_q == S_DONE);
  assign wr_ok_s     = exp_wr_en && idle_like_s &&
                       ({1'b0, exp_wr_idx} < (IDX_W+1)'(NUM_REGS));
  // rf_rd_data carries the register addressed by cmp_idx_q whenever cmp_valid_q is set
  assign mismatch_s  = cmp_valid_q &&
                       (((rf_rd_data ^ exp_data_q[cmp_idx_q]) & exp_mask_q[cmp_idx_q])
                        != {DATA_W{1'b0}});

  // Next-state logic for the run/scan sequencer and the result registers
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_len_d    = run_len_q;
    rd_idx_d     = rd_idx_q;
    issued_all_d = issued_all_q;
    cmp_valid_d  = cmp_valid_q;
    cmp_idx_d    = cmp_idx_q;
    err_count_d  = err_count_q;
    first_idx_d  = first_idx_q;
    first_act_d  = first_act_q;
    first_exp_d  = first_exp_q;
    done_d       = done_q;
    pass_d       = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          run_len_d    = run_cycles;
          cnt_d        = {CNT_W{1'b0}};
          rd_idx_d     = {IDX_W{1'b0}};
          issued_all_d = 1'b0;
          cmp_valid_d  = 1'b0;
          cmp_idx_d    = {IDX_W{1'b0}};
          err_count_d  = {(IDX_W+1){1'b0}};
          first_idx_d  = {IDX_W{1'b0}};
          first_act_d  = {DATA_W{1'b0}};
          first_exp_d  = {DATA_W{1'b0}};
          done_d       = 1'b0;
          pass_d       = 1'b0;
          state_d      = (run_cycles == {CNT_W{1'b0}}) ? S_SCAN : S_RUN;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (cnt_q == (run_len_q - CNT_W'(1))) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_SCAN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SCAN: begin
        // Issue stage: one index per cycle, then a single drain cycle
        if (!issued_all_q) begin
          cmp_valid_d = 1'b1;
          cmp_idx_d   = rd_idx_q;
          if (rd_idx_q == LAST_IDX) begin
            issued_all_d = 1'b1;
            rd_idx_d     = {IDX_W{1'b0}};
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end else begin
          cmp_valid_d = 1'b0;
        end
        // Compare stage, one cycle behind the issue stage
        if (mismatch_s) begin
          err_count_d = err_count_q + (IDX_W+1)'(1);
          if (err_count_q == {(IDX_W+1){1'b0}}) begin
            first_idx_d = cmp_idx_q;
            first_act_d = rf_rd_data;
            first_exp_d = exp_data_q[cmp_idx_q];
          end else begin
            first_idx_d = first_idx_q;
          end
        end else begin
          err_count_d = err_count_q;
        end
        if (cmp_valid_q && (cmp_idx_q == LAST_IDX)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_count_d == {(IDX_W+1){1'b0}});
        end else begin
          state_d = S_SCAN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    core_run_d = (state_d == S_RUN);
    busy_d     = (state_d == S_RUN) || (state_d == S_SCAN);
  end

  // Sequencer and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      run_len_q    <= {CNT_W{1'b0}};
      rd_idx_q     <= {IDX_W{1'b0}};
      issued_all_q <= 1'b0;
      cmp_valid_q  <= 1'b0;
      cmp_idx_q    <= {IDX_W{1'b0}};
      err_count_q  <= {(IDX_W+1){1'b0}};
      first_idx_q  <= {IDX_W{1'b0}};
      first_act_q  <= {DATA_W{1'b0}};
      first_exp_q  <= {DATA_W{1'b0}};
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      core_run_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_len_q    <= run_len_d;
      rd_idx_q     <= rd_idx_d;
      issued_all_q <= issued_all_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_idx_q    <= cmp_idx_d;
      err_count_q  <= err_count_d;
      first_idx_q  <= first_idx_d;
      first_act_q  <= first_act_d;
      first_exp_q  <= first_exp_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      core_run_q   <= core_run_d;
      busy_q       <= busy_d;
    end
  end

  // Expected masks: a reset from IDLE/DONE clears them so unwritten entries
  // always match; a reset that aborts a run keeps them so the run can be
  // repeated without reloading the expected image.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rstb && !busy_q) begin
        exp_mask_q[i] <= {DATA_W{1'b0}};
      end else if (!rstb && wr_ok_s && (exp_wr_idx == IDX_W'(i))) begin
        exp_mask_q[i] <= exp_wr_mask;
      end else begin
        exp_mask_q[i] <= exp_mask_q[i];
      end
    end
  end

  // Expected data: never reset, written only while not busy
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!rstb && wr_ok_s && (exp_wr_idx == IDX_W'(i))) begin
        exp_data_q[i] <= exp_wr_data;
      end else begin
        exp_data_q[i] <= exp_data_q[i];
      end
    end
  end

  assign core_run      = core_run_q;
  assign busy          = busy_q;
  assign rf_rd_idx     = rd_idx_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_idx_q;
  assign first_err_act = first_act_q;
  assign first_err_exp = first_exp_q;

endmodule
